// File: rtl/snake_engine_grid.sv
`timescale 1ns/1ps
// snake_engine_grid: grid snake game engine (body, apple, score, game FSM)
// with a registered per-pixel RGB output driven from VGA timing.
module snake_engine_grid #(
    parameter int CELL_LOG2 = 4,
    parameter int GRID_W    = 40,
    parameter int GRID_H    = 30,
    parameter int MAX_LEN   = 32,
    parameter int START_LEN = 4,
    parameter int SCORE_W   = 8
) (
    input  logic               CLK_100MHz,
    input  logic               Reset,
    input  logic               tick,
    input  logic               go,
    input  logic [1:0]         dir,
    input  logic [10:0]        randX,
    input  logic [10:0]        randY,
    input  logic [10:0]        CurrentX,
    input  logic [10:0]        CurrentY,
    input  logic               HBlank,
    input  logic               VBlank,
    output logic [3:0]         RED,
    output logic [3:0]         GREEN,
    output logic [3:0]         BLUE,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         state
);
    // state  | meaning
    // IDLE   | waiting for go, snake parked at its start position
    // RUN    | moving one cell per tick
    // OVER   | collision seen, body frozen, go returns to IDLE
    typedef enum logic [1:0] {S_IDLE = 2'b00, S_RUN = 2'b01, S_OVER = 2'b10} state_t;

    localparam int          LEN_W     = $clog2(MAX_LEN + 1);
    localparam logic [10:0] C_MAX_X   = 11'(GRID_W - 1);
    localparam logic [10:0] C_MAX_Y   = 11'(GRID_H - 1);
    localparam logic [10:0] C_HEAD_X  = 11'(GRID_W / 2);
    localparam logic [10:0] C_HEAD_Y  = 11'(GRID_H / 2);
    localparam logic [10:0] C_APPLE_X = 11'(3 * GRID_W / 4);
    localparam logic [1:0]  D_UP = 2'd0, D_RIGHT = 2'd1, D_DOWN = 2'd2, D_LEFT = 2'd3;

    state_t              r_state, w_state_nxt;
    logic [10:0]         r_seg_x [MAX_LEN];
    logic [10:0]         r_seg_y [MAX_LEN];
    logic [LEN_W-1:0]    r_len;
    logic [1:0]          r_heading, r_pend_dir;
    logic [10:0]         r_apple_x, r_apple_y;
    logic                r_apple_pend;
    logic [SCORE_W-1:0]  r_score;
    logic [11:0]         r_rgb;

    logic                w_restart, w_move, w_step, w_collide, w_hit_body, w_eat, w_apple_ok;
    logic [10:0]         w_nh_x, w_nh_y, w_cx, w_cy;
    logic [1:0]          w_heading_eff;
    logic                w_on_head, w_on_body, w_on_apple, w_on_border;
    logic [11:0]         w_rgb_nxt;

    assign w_restart = (r_state == S_OVER) && go;
    assign w_move    = (r_state == S_RUN) && tick;
    assign w_step    = w_move && !w_collide;

    // The move goes in the already reversal-filtered pending direction.
    always_comb begin
        w_nh_x = r_seg_x[0];
        w_nh_y = r_seg_y[0];
        case (r_pend_dir)
            D_UP:    w_nh_y = r_seg_y[0] - 11'd1;
            D_RIGHT: w_nh_x = r_seg_x[0] + 11'd1;
            D_DOWN:  w_nh_y = r_seg_y[0] + 11'd1;
            default: w_nh_x = r_seg_x[0] - 11'd1;
        endcase
    end

    // Self collision against seg[0..len-2]; the tail cell is vacated by the same move.
    always_comb begin
        w_hit_body = 1'b0;
        for (int k = 0; k < MAX_LEN - 1; k++) begin
            if ((LEN_W'(k + 1) < r_len) && (w_nh_x == r_seg_x[k]) && (w_nh_y == r_seg_y[k]))
                w_hit_body = 1'b1;
        end
    end

    assign w_collide = w_hit_body || (w_nh_x == 11'd0) || (w_nh_x == C_MAX_X) ||
                       (w_nh_y == 11'd0) || (w_nh_y == C_MAX_Y);
    assign w_eat     = !r_apple_pend && (w_nh_x == r_apple_x) && (w_nh_y == r_apple_y);
    assign w_apple_ok = (randX >= 11'd1) && (randX <= C_MAX_X - 11'd1) &&
                        (randY >= 11'd1) && (randY <= C_MAX_Y - 11'd1) &&
                        !((randX == r_seg_x[0]) && (randY == r_seg_y[0]));
    // Filter reversals against the heading in force after this cycle's move.
    assign w_heading_eff = w_step ? r_pend_dir : r_heading;

    // Game state register.
    always_ff @(posedge CLK_100MHz) begin
        if (Reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Game state transitions.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (go) w_state_nxt = S_RUN;
            S_RUN:   if (w_move && w_collide) w_state_nxt = S_OVER;
            S_OVER:  if (go) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Snake body, heading, apple and score.
    always_ff @(posedge CLK_100MHz) begin
        if (Reset || w_restart) begin
            for (int k = 0; k < MAX_LEN; k++) begin
                r_seg_x[k] <= (k < START_LEN) ? C_HEAD_X - 11'(k) : 11'd0;
                r_seg_y[k] <= (k < START_LEN) ? C_HEAD_Y : 11'd0;
            end
            r_len        <= LEN_W'(START_LEN);
            r_heading    <= D_RIGHT;
            r_pend_dir   <= D_RIGHT;
            r_apple_x    <= C_APPLE_X;
            r_apple_y    <= C_HEAD_Y;
            r_apple_pend <= 1'b0;
            r_score      <= '0;
        end else begin
            if (r_state == S_RUN && dir != (w_heading_eff ^ 2'b10))
                r_pend_dir <= dir;
            if (w_step) begin
                for (int k = 1; k < MAX_LEN; k++) begin
                    r_seg_x[k] <= r_seg_x[k-1];
                    r_seg_y[k] <= r_seg_y[k-1];
                end
                r_seg_x[0] <= w_nh_x;
                r_seg_y[0] <= w_nh_y;
                r_heading  <= r_pend_dir;
                if (w_eat) begin
                    if (r_len != LEN_W'(MAX_LEN)) r_len <= r_len + 1'b1;
                    if (r_score != {SCORE_W{1'b1}}) r_score <= r_score + 1'b1;
                    r_apple_pend <= 1'b1;
                end
            end
            if (r_apple_pend && w_apple_ok) begin
                r_apple_x    <= randX;
                r_apple_y    <= randY;
                r_apple_pend <= 1'b0;
            end
        end
    end

    assign w_cx = CurrentX >> CELL_LOG2;
    assign w_cy = CurrentY >> CELL_LOG2;

    // Cell classification of the current pixel.
    always_comb begin
        w_on_body = 1'b0;
        for (int k = 1; k < MAX_LEN; k++) begin
            if ((LEN_W'(k) < r_len) && (w_cx == r_seg_x[k]) && (w_cy == r_seg_y[k]))
                w_on_body = 1'b1;
        end
    end

    assign w_on_head   = (w_cx == r_seg_x[0]) && (w_cy == r_seg_y[0]);
    assign w_on_apple  = !r_apple_pend && (w_cx == r_apple_x) && (w_cy == r_apple_y);
    assign w_on_border = (w_cx == 11'd0) || (w_cx == C_MAX_X) || (w_cy == 11'd0) || (w_cy == C_MAX_Y);

    // Colour priority: blank > head > body > apple > border > black.
    always_comb begin
        w_rgb_nxt = 12'h000;
        if (HBlank || VBlank)   w_rgb_nxt = 12'h000;
        else if (w_on_head)     w_rgb_nxt = (r_state == S_OVER) ? 12'hF00 : 12'h0F0;
        else if (w_on_body)     w_rgb_nxt = (r_state == S_OVER) ? 12'hF00 : 12'h080;
        else if (w_on_apple)    w_rgb_nxt = 12'hF00;
        else if (w_on_border)   w_rgb_nxt = 12'h00F;
    end

    // Registered pixel output.
    always_ff @(posedge CLK_100MHz) begin
        if (Reset || w_restart) r_rgb <= 12'h000;
        else                    r_rgb <= w_rgb_nxt;
    end

    assign RED   = r_rgb[11:8];
    assign GREEN = r_rgb[7:4];
    assign BLUE  = r_rgb[3:0];
    assign score = r_score;
    assign state = r_state;
endmodule

// File: tb/tb_snake_engine_grid.sv
`timescale 1ns/1ps
// Directed bench for snake_engine_grid with hand-computed expectations.
module tb_snake_engine_grid;
    logic        CLK_100MHz = 1'b0;
    logic        Reset, tick, go, HBlank, VBlank;
    logic [1:0]  dir;
    logic [10:0] randX, randY, CurrentX, CurrentY;
    logic [3:0]  RED, GREEN, BLUE;
    logic [7:0]  score;
    logic [1:0]  state;

    int n_checks = 0;
    int n_errors = 0;

    snake_engine_grid dut (
        .CLK_100MHz(CLK_100MHz), .Reset(Reset), .tick(tick), .go(go), .dir(dir),
        .randX(randX), .randY(randY), .CurrentX(CurrentX), .CurrentY(CurrentY),
        .HBlank(HBlank), .VBlank(VBlank), .RED(RED), .GREEN(GREEN), .BLUE(BLUE),
        .score(score), .state(state)
    );

    always #5 CLK_100MHz = ~CLK_100MHz;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK_100MHz);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        step();
        tick = 1'b0;
        step();
    endtask

    task automatic turn(input logic [1:0] d);
        dir = d;
        step();
        do_tick();
    endtask

    task automatic pulse_go();
        go = 1'b1;
        step();
        go = 1'b0;
    endtask

    task automatic chk_head(input string tag, input int x, input int y);
        chk({tag, "_hx"}, 32'(dut.r_seg_x[0]), 32'(x));
        chk({tag, "_hy"}, 32'(dut.r_seg_y[0]), 32'(y));
    endtask

    task automatic pix(input string tag, input int px, input int py, input logic [11:0] exp);
        CurrentX = 11'(px);
        CurrentY = 11'(py);
        step();
        chk(tag, {20'd0, RED, GREEN, BLUE}, {20'd0, exp});
    endtask

    initial begin
        Reset = 1'b1; tick = 1'b0; go = 1'b0; dir = 2'b01;
        randX = 11'd0; randY = 11'd5; CurrentX = 11'd320; CurrentY = 11'd240;
        HBlank = 1'b0; VBlank = 1'b0;
        step(); step();
        chk("rst_rgb", {20'd0, RED, GREEN, BLUE}, 32'h000);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk_head("rst", 20, 15);
        chk("rst_len", 32'(dut.r_len), 32'd4);
        chk("rst_seg3x", 32'(dut.r_seg_x[3]), 32'd17);
        chk("rst_seg4x", 32'(dut.r_seg_x[4]), 32'd0);
        chk("rst_apple_x", 32'(dut.r_apple_x), 32'd30);
        chk("rst_apple_y", 32'(dut.r_apple_y), 32'd15);

        Reset = 1'b0;
        pix("pix_head_idle", 320, 240, 12'h0F0);
        HBlank = 1'b1;
        pix("pix_hblank", 320, 240, 12'h000);
        HBlank = 1'b0;
        VBlank = 1'b1;
        pix("pix_vblank", 320, 240, 12'h000);
        VBlank = 1'b0;

        do_tick();
        chk_head("idle_tick", 20, 15);

        // go accepted with a tick in the same cycle: tick ignored
        tick = 1'b1;
        pulse_go();
        tick = 1'b0;
        chk("go_state", 32'(state), 32'd1);
        chk_head("go_tick", 20, 15);

        turn(2'b11);
        chk_head("reversal", 21, 15);
        dir = 2'b01;
        do_tick();
        do_tick();
        chk_head("t1", 23, 15);
        chk("t1_len", 32'(dut.r_len), 32'd4);
        chk("t1_state", 32'(state), 32'd1);
        chk("t1_score", 32'(score), 32'd0);
        chk("t1_seg3x", 32'(dut.r_seg_x[3]), 32'd20);

        for (int i = 0; i < 6; i++) do_tick();
        chk_head("pre_eat", 29, 15);
        randX = 11'd0; randY = 11'd5;
        tick = 1'b1;
        step();
        tick = 1'b0;
        chk_head("eat", 30, 15);
        chk("eat_len", 32'(dut.r_len), 32'd5);
        chk("eat_score", 32'(score), 32'd1);
        chk("eat_pend", 32'(dut.r_apple_pend), 32'd1);
        chk("eat_seg4x", 32'(dut.r_seg_x[4]), 32'd26);
        step();
        chk("rej_x0_a", 32'(dut.r_apple_pend), 32'd1);
        randX = 11'd30; randY = 11'd15;
        step();
        chk("rej_head", 32'(dut.r_apple_pend), 32'd1);
        randX = 11'd5; randY = 11'd5;
        step();
        chk("acc_pend", 32'(dut.r_apple_pend), 32'd0);
        chk("acc_x", 32'(dut.r_apple_x), 32'd5);
        chk("acc_y", 32'(dut.r_apple_y), 32'd5);

        pix("pix_apple", 83, 83, 12'hF00);
        pix("pix_body", 464, 240, 12'h080);
        pix("pix_border", 0, 0, 12'h00F);
        pix("pix_black", 160, 160, 12'h000);
        CurrentX = 11'd320; CurrentY = 11'd240;

        for (int i = 0; i < 8; i++) do_tick();
        chk_head("pre_wall", 38, 15);
        do_tick();
        chk("wall_state", 32'(state), 32'd2);
        chk_head("wall", 38, 15);
        chk("wall_seg1x", 32'(dut.r_seg_x[1]), 32'd37);
        chk("wall_seg4x", 32'(dut.r_seg_x[4]), 32'd34);
        chk("wall_score", 32'(score), 32'd1);
        pix("pix_over_head", 608, 240, 12'hF00);
        pix("pix_over_body", 592, 240, 12'hF00);
        do_tick();
        chk_head("over_tick", 38, 15);

        pulse_go();
        chk("restart_state", 32'(state), 32'd0);
        chk_head("restart", 20, 15);
        chk("restart_len", 32'(dut.r_len), 32'd4);
        chk("restart_score", 32'(score), 32'd0);
        chk("restart_apple_x", 32'(dut.r_apple_x), 32'd30);
        chk("restart_seg4x", 32'(dut.r_seg_x[4]), 32'd0);
        chk("restart_rgb", {20'd0, RED, GREEN, BLUE}, 32'h000);
        step();
        chk("idle_hold", 32'(state), 32'd0);

        pulse_go();
        turn(2'b00);
        chk_head("loop_up", 20, 14);
        turn(2'b11);
        chk_head("loop_left", 19, 14);
        turn(2'b10);
        chk_head("loop_tail1", 19, 15);
        chk("loop_tail1_st", 32'(state), 32'd1);
        turn(2'b01);
        chk_head("loop_tail2", 20, 15);
        chk("loop_tail2_st", 32'(state), 32'd1);

        for (int i = 0; i < 10; i++) do_tick();
        chk_head("eat2", 30, 15);
        chk("eat2_len", 32'(dut.r_len), 32'd5);
        chk("eat2_apple_x", 32'(dut.r_apple_x), 32'd5);
        turn(2'b00);
        turn(2'b11);
        chk_head("loop5_left", 29, 14);
        turn(2'b10);
        chk("loop5_state", 32'(state), 32'd2);
        chk_head("loop5", 29, 14);

        pulse_go();
        pulse_go();
        do_tick();
        chk("mid_state", 32'(state), 32'd1);
        chk_head("mid", 21, 15);
        Reset = 1'b1;
        step();
        Reset = 1'b0;
        chk("mrst_state", 32'(state), 32'd0);
        chk_head("mrst", 20, 15);
        chk("mrst_len", 32'(dut.r_len), 32'd4);
        chk("mrst_score", 32'(score), 32'd0);
        chk("mrst_apple_x", 32'(dut.r_apple_x), 32'd30);
        chk("mrst_rgb", {20'd0, RED, GREEN, BLUE}, 32'h000);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
